shared_fu_issue_arbiter: RTL and testbench



---
 rtl/shared_fu_issue_arbiter_pkg.sv | 40 ++++
 rtl/shared_fu_issue_arbiter_if.sv | 44 ++++
 rtl/shared_fu_issue_arbiter_age_oldest_select.sv | 43 ++++
 rtl/shared_fu_issue_arbiter.sv | 124 ++++++++++++
 tb/tb_shared_fu_issue_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_fu_issue_arbiter_pkg.sv
// Scheduler package shared by the FU issue arbiter and the RS select logic.
//   - ROB geometry and the widest ROB index the age compare accepts
//   - issue payload / option-code types carried to the shared FU
//   - FSM state enum of the shared-FU arbiter
//   - rob_older(): wrap-aware ROB age comparison
package shared_fu_issue_arbiter_pkg;

  localparam int ROB_DEPTH     = 64;
  localparam int ROB_IDX_MAX_W = 16;  // rob_older() operands are zero-extended to this

  typedef struct packed {
    logic [5:0]  dst_preg;
    logic [5:0]  src1_preg;
    logic [5:0]  src2_preg;
    logic [15:0] imm;
  } issue_base_t;

  typedef struct packed {
    logic [3:0] fu_op;
    logic       is_signed;
  } option_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fu_arb_state_e;

  // a is older than b. Same wrap bit: smaller index is older. Different
  // wrap bits: the ROB pointer has wrapped between them, so the larger
  // index belongs to the earlier lap.
  function automatic logic rob_older(input logic                     pos_a,
                                     input logic [ROB_IDX_MAX_W-1:0] idx_a,
                                     input logic                     pos_b,
                                     input logic [ROB_IDX_MAX_W-1:0] idx_b);
    if (pos_a == pos_b) return (idx_a < idx_b);
    else                return (idx_a > idx_b);
  endfunction

endpackage

// File: rtl/shared_fu_issue_arbiter_if.sv
// Bundle between the RS issue ports / writeback side and the shared-FU
// arbiter.
//   master : RS issue ports + writeback consumer (drives req_*, wb_ready_i)
//   slave  : the arbiter (drives req_ready_o, fu_*, wb_valid_o, busy_o, dbg_state_o)
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. req_ready_o is combinational from req_* and is
// one-hot or zero; a requester may drop req_valid_i without a transfer.
// wb_valid_o is registered and stays high until wb_ready_i is seen with it.
interface shared_fu_issue_arbiter_if
  import shared_fu_issue_arbiter_pkg::*;
#(
  parameter int  REQ_NUM     = 2,
  parameter int  ROB_W       = $clog2(ROB_DEPTH),
  parameter type OPTION_CODE = option_code_t
);

  logic [REQ_NUM-1:0] req_valid_i;
  logic [REQ_NUM-1:0] req_ready_o;
  issue_base_t        req_base_i    [REQ_NUM];
  OPTION_CODE         req_oc_i      [REQ_NUM];
  logic [REQ_NUM-1:0] req_pos_bit_i;
  logic [ROB_W-1:0]   req_rob_idx_i [REQ_NUM];

  logic               fu_start_o;
  issue_base_t        fu_base_o;
  OPTION_CODE         fu_oc_o;

  logic               wb_valid_o;
  logic               wb_ready_i;
  logic               busy_o;
  fu_arb_state_e      dbg_state_o;

  modport master (
    output req_valid_i, req_base_i, req_oc_i, req_pos_bit_i, req_rob_idx_i, wb_ready_i,
    input  req_ready_o, fu_start_o, fu_base_o, fu_oc_o, wb_valid_o, busy_o, dbg_state_o
  );

  modport slave (
    input  req_valid_i, req_base_i, req_oc_i, req_pos_bit_i, req_rob_idx_i, wb_ready_i,
    output req_ready_o, fu_start_o, fu_base_o, fu_oc_o, wb_valid_o, busy_o, dbg_state_o
  );

endinterface

// File: rtl/shared_fu_issue_arbiter_age_oldest_select.sv
// age_oldest_select: combinational oldest-of-N picker by ROB age.
//   valid_i     : request valid per slot
//   pos_i       : ROB wrap bit per slot
//   idx_i       : ROB index per slot
//   sel_o       : one-hot oldest valid slot (zero when nothing is valid)
//   any_valid_o : at least one slot valid
// Ties in age go to the lowest slot index.
module age_oldest_select
  import shared_fu_issue_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int ROB_W = 6
) (
  input  logic [N-1:0]     valid_i,
  input  logic [N-1:0]     pos_i,
  input  logic [ROB_W-1:0] idx_i [N],
  output logic [N-1:0]     sel_o,
  output logic             any_valid_o
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [SEL_W-1:0] best;

  always_comb begin
    any_valid_o = 1'b0;
    best        = '0;
    sel_o       = '0;
    // Scan upward; a later slot replaces the current best only when strictly
    // older, which gives the lower index the win on equal age.
    for (int i = 0; i < N; i++) begin
      if (valid_i[i] &&
          (!any_valid_o ||
           rob_older(pos_i[i], ROB_IDX_MAX_W'(idx_i[i]),
                     pos_i[best], ROB_IDX_MAX_W'(idx_i[best])))) begin
        best        = SEL_W'(i);
        any_valid_o = 1'b1;
      end
    end
    if (any_valid_o) sel_o[best] = 1'b1;
  end

endmodule

// File: rtl/shared_fu_issue_arbiter.sv
// shared_fu_issue_arbiter: shares one unpipelined multi-cycle FU between
// REQ_NUM RS issue ports. Grants the oldest valid requester, latches its
// payload for the FU, counts FU_LATENCY cycles and then presents the result
// for writeback; no new grant until the writeback is accepted.
//   clk, rst : clock, synchronous active-high reset
//   flush_i  : kill the in-flight op, return to IDLE next cycle
//   bus      : slave side of shared_fu_issue_arbiter_if (requests, FU
//              start/payload, writeback handshake, busy, FSM state)
module shared_fu_issue_arbiter
  import shared_fu_issue_arbiter_pkg::*;
#(
  parameter int  REQ_NUM     = 2,
  parameter int  FU_LATENCY  = 4,
  parameter int  ROB_W       = $clog2(ROB_DEPTH),
  parameter type OPTION_CODE = option_code_t
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      flush_i,
  shared_fu_issue_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FU_LATENCY + 1);

  fu_arb_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fu_start_q;
  issue_base_t        base_q, base_sel;
  OPTION_CODE         oc_q, oc_sel;
  logic [REQ_NUM-1:0] sel;
  logic               any_valid;
  logic               accept_en;
  logic               grant;

  age_oldest_select #(
    .N     (REQ_NUM),
    .ROB_W (ROB_W)
  ) u_age_oldest_select (
    .valid_i     (bus.req_valid_i),
    .pos_i       (bus.req_pos_bit_i),
    .idx_i       (bus.req_rob_idx_i),
    .sel_o       (sel),
    .any_valid_o (any_valid)
  );

  // Accepting from DONE needs the writeback to leave in the same cycle,
  // which is what allows back-to-back ops with no bubble.
  assign accept_en = !flush_i &&
                     ((state_q == IDLE) || ((state_q == DONE) && bus.wb_ready_i));
  assign grant     = accept_en && any_valid;

  always_comb begin
    base_sel = '0;
    oc_sel   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (sel[i]) begin
        base_sel = bus.req_base_i[i];
        oc_sel   = bus.req_oc_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(FU_LATENCY);
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.wb_ready_i) begin
          if (grant) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(FU_LATENCY);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fu_start_q <= 1'b0;
      base_q     <= '0;
      oc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fu_start_q <= grant;
      if (flush_i) begin
        base_q <= '0;
        oc_q   <= '0;
      end else if (grant) begin
        base_q <= base_sel;
        oc_q   <= oc_sel;
      end
    end
  end

  assign bus.req_ready_o = sel & {REQ_NUM{accept_en}};
  assign bus.fu_start_o  = fu_start_q;
  assign bus.fu_base_o   = base_q;
  assign bus.fu_oc_o     = oc_q;
  assign bus.wb_valid_o  = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_shared_fu_issue_arbiter.sv
module tb_shared_fu_issue_arbiter;
  import shared_fu_issue_arbiter_pkg::*;

  localparam int REQ_NUM = 2;
  localparam int LAT     = 4;
  localparam int ROB_W   = $clog2(ROB_DEPTH);
  localparam int PW      = $bits(issue_base_t) + $bits(option_code_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  shared_fu_issue_arbiter_if #(.REQ_NUM(REQ_NUM), .ROB_W(ROB_W)) bus  ();
  shared_fu_issue_arbiter_if #(.REQ_NUM(REQ_NUM), .ROB_W(ROB_W)) bus1 ();

  shared_fu_issue_arbiter #(
    .REQ_NUM(REQ_NUM), .FU_LATENCY(LAT), .ROB_W(ROB_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .bus(bus)
  );

  // Latency-1 instance runs on the same stimulus.
  shared_fu_issue_arbiter #(
    .REQ_NUM(REQ_NUM), .FU_LATENCY(1), .ROB_W(ROB_W)
  ) dut_l1 (
    .clk(clk), .rst(rst), .flush_i(flush), .bus(bus1)
  );

  assign bus1.req_valid_i   = bus.req_valid_i;
  assign bus1.req_base_i    = bus.req_base_i;
  assign bus1.req_oc_i      = bus.req_oc_i;
  assign bus1.req_pos_bit_i = bus.req_pos_bit_i;
  assign bus1.req_rob_idx_i = bus.req_rob_idx_i;
  assign bus1.wb_ready_i    = bus.wb_ready_i;

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic tb_older(input int a, input int b);
    logic pa, pb;
    int   ia, ib;
    pa = bus.req_pos_bit_i[a];
    pb = bus.req_pos_bit_i[b];
    ia = int'(bus.req_rob_idx_i[a]);
    ib = int'(bus.req_rob_idx_i[b]);
    return (pa == pb) ? (ia < ib) : (ia > ib);
  endfunction

  function automatic logic [REQ_NUM-1:0] model_pick();
    int w;
    logic [REQ_NUM-1:0] r;
    w = -1;
    r = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (bus.req_valid_i[i] && (w < 0 || tb_older(i, w))) w = i;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int p, input logic pos, input logic [ROB_W-1:0] idx);
    issue_base_t  b;
    option_code_t o;
    b.dst_preg  = 6'($urandom_range(0, 63));
    b.src1_preg = 6'($urandom_range(0, 63));
    b.src2_preg = 6'($urandom_range(0, 63));
    b.imm       = 16'($urandom_range(1, 65535));
    o.fu_op     = 4'($urandom_range(0, 15));
    o.is_signed = 1'($urandom_range(0, 1));
    bus.req_valid_i[p]   = 1'b1;
    bus.req_pos_bit_i[p] = pos;
    bus.req_rob_idx_i[p] = idx;
    bus.req_base_i[p]    = b;
    bus.req_oc_i[p]      = o;
  endtask

  task automatic clear_reqs();
    bus.req_valid_i = '0;
  endtask

  // Checks the combinational grant and queues the winner's payload.
  task automatic offer(input string tag, input logic [REQ_NUM-1:0] exp);
    #1;
    check_eq({tag, "_ready"}, 64'(bus.req_ready_o), 64'(exp));
    for (int i = 0; i < REQ_NUM; i++)
      if (exp[i]) exp_q.push_back({bus.req_base_i[i], bus.req_oc_i[i]});
  endtask

  task automatic issue(input string tag, input logic [REQ_NUM-1:0] exp);
    offer(tag, exp);
    tick();
    clear_reqs();
  endtask

  // Entered one cycle after the accept edge.
  task automatic expect_latency(input string tag, input int lat);
    int n;
    n = 0;
    check_eq({tag, "_start"}, 64'(bus.fu_start_o), 64'(1));
    check_eq({tag, "_busy"}, 64'(bus.busy_o), 64'(1));
    while (!bus.wb_valid_o && n < 40) begin
      tick();
      n++;
      if (n == 1) check_eq({tag, "_start_pulse"}, 64'(bus.fu_start_o), 64'(0));
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic pop_compare(input string tag);
    logic [PW-1:0] e;
    check_eq({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_payload"}, 64'({bus.fu_base_o, bus.fu_oc_o}), 64'(e));
    end
  endtask

  task automatic wb_accept(input string tag);
    check_eq({tag, "_wb_valid"}, 64'(bus.wb_valid_o), 64'(1));
    check_eq({tag, "_state"}, 64'(bus.dbg_state_o), 64'(DONE));
    bus.wb_ready_i = 1'b1;
    #1;
    pop_compare(tag);
  endtask

  task automatic complete(input string tag);
    expect_latency(tag, LAT);
    wb_accept(tag);
    tick();
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
    check_eq({tag, "_wb"}, 64'(bus.wb_valid_o), 64'(0));
    check_eq({tag, "_start"}, 64'(bus.fu_start_o), 64'(0));
    check_eq({tag, "_base"}, 64'(bus.fu_base_o), 64'(0));
    check_eq({tag, "_oc"}, 64'(bus.fu_oc_o), 64'(0));
    check_eq({tag, "_state"}, 64'(bus.dbg_state_o), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic wb_seen;
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid_i   = '0;
    bus.req_pos_bit_i = '0;
    bus.wb_ready_i    = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      bus.req_rob_idx_i[i] = '0;
      bus.req_base_i[i]    = '0;
      bus.req_oc_i[i]      = '0;
    end
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (6) tick();

    // 1: single request, latency and wb hold
    set_req(0, 1'b0, 6'd5);
    issue("t1", 2'b01);
    expect_latency("t1", LAT);
    set_req(1, 1'b0, 6'd1);
    for (int k = 0; k < 3; k++) begin
      offer("t1_hold", 2'b00);
      check_eq("t1_wb_held", 64'(bus.wb_valid_o), 64'(1));
      tick();
    end
    clear_reqs();
    wb_accept("t1");
    tick();
    bus.wb_ready_i = 1'b0;
    check_eq("t1_back_idle", 64'(bus.busy_o), 64'(0));

    // 2: younger port0 vs older port1
    set_req(0, 1'b0, 6'd7);
    set_req(1, 1'b0, 6'd3);
    issue("t2", 2'b10);
    complete("t2");

    // 3: wrapped ages, then equal ages
    set_req(0, 1'b1, 6'd2);
    set_req(1, 1'b0, 6'd30);
    issue("t3_wrap", 2'b10);
    complete("t3_wrap");
    set_req(0, 1'b0, 6'd9);
    set_req(1, 1'b0, 6'd9);
    issue("t3_tie", 2'b01);
    complete("t3_tie");

    // random ages with frequent ties
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1)) set_req(0, 1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 3)));
      if ($urandom_range(0, 1)) set_req(1, 1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 3)));
      if (bus.req_valid_i == '0) set_req(1, 1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 3)));
      issue("rnd", model_pick());
      complete("rnd");
    end

    // 4: back-to-back accept in DONE
    set_req(0, 1'b0, 6'd4);
    issue("t4a", 2'b01);
    expect_latency("t4a", LAT);
    set_req(0, 1'b0, 6'd6);
    wb_accept("t4a");
    offer("t4_b2b", 2'b01);
    tick();
    clear_reqs();
    bus.wb_ready_i = 1'b0;
    check_eq("t4_wb_low", 64'(bus.wb_valid_o), 64'(0));
    complete("t4b");

    // 5: flush at cnt==2 with a request present
    set_req(0, 1'b1, 6'd10);
    issue("t5", 2'b01);
    tick();
    tick();
    flush = 1'b1;
    set_req(1, 1'b0, 6'd1);
    offer("t5_flush", 2'b00);
    tick();
    flush = 1'b0;
    clear_reqs();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    check_idle_outputs("t5_post");
    wb_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      wb_seen = wb_seen | bus.wb_valid_o;
    end
    check_eq("t5_wb_never", 64'(wb_seen), 64'(0));
    set_req(1, 1'b0, 6'd1);
    issue("t5_next", 2'b10);
    complete("t5_next");

    // 6: reset in DONE, then latency-1 instance
    set_req(0, 1'b0, 6'd2);
    issue("t6", 2'b01);
    expect_latency("t6", LAT);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check_idle_outputs("t6_rst");
    check_eq("t6_rst_l1_busy", 64'(bus1.busy_o), 64'(0));
    rst = 1'b0;
    tick();
    set_req(0, 1'b0, 6'd8);
    offer("t6_l4", 2'b01);
    check_eq("t6_l1_ready", 64'(bus1.req_ready_o), 64'(2'b01));
    tick();
    clear_reqs();
    check_eq("t6_l1_start", 64'(bus1.fu_start_o), 64'(1));
    check_eq("t6_l1_wb_early", 64'(bus1.wb_valid_o), 64'(0));
    tick();
    check_eq("t6_l1_wb", 64'(bus1.wb_valid_o), 64'(1));
    check_eq("t6_l1_start_pulse", 64'(bus1.fu_start_o), 64'(0));
    check_eq("t6_l1_payload", 64'({bus1.fu_base_o, bus1.fu_oc_o}), 64'(exp_q[0]));
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    check_eq("t6_l1_wb_done", 64'(bus1.wb_valid_o), 64'(0));
    n = 0;
    while (!bus.wb_valid_o && n < 40) begin
      tick();
      n++;
    end
    check_eq("t6_l4_remaining", 64'(n), 64'(2));
    wb_accept("t6_l4");
    tick();
    bus.wb_ready_i = 1'b0;

    check_eq("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
